// File: rtl/mem_responder.sv
// mem_responder: data-memory responder returning in-order load/store responses after a fixed latency
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake; req_addr byte address, req_we store, req_be lanes, req_wdata
//   resp_valid/ready  response handshake; resp_rdata load data (0 for stores/errors), resp_err fault
module mem_responder #(
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   logic [31:0]   mem_q [DEPTH];
   logic [32:0]   fifo_q [FIFO_DEPTH];
   logic [CW-1:0] out_q, out_d, fcnt_q, fcnt_d;
   logic [PW-1:0] head_q, tail_q;
   logic [AW-1:0] idx;
   logic          acc, pop, push, err_w;
   logic [33:0]   in_w, push_w;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   assign req_ready = out_q < CW'(FIFO_DEPTH);
   assign acc       = req_valid && req_ready;
   assign pop       = resp_valid && resp_ready;
   assign push      = push_w[33];
   assign idx       = req_addr[AW+1:2];
   assign err_w     = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
   // {valid, err, rdata} entering the latency line; load data is sampled at the accept edge
   assign in_w      = {acc, err_w, (acc && !req_we && !err_w) ? mem_q[idx] : 32'h0};
   assign out_d     = out_q + CW'(acc) - CW'(pop);
   assign fcnt_d    = fcnt_q + CW'(push) - CW'(pop);
   assign resp_valid = fcnt_q != '0;
   assign {resp_err, resp_rdata} = resp_valid ? fifo_q[head_q] : 33'h0;
   // The FIFO write is the last latency stage, so only LATENCY-1 registers sit in front of it
   generate
      if (LATENCY == 1) begin : g_direct
         assign push_w = in_w;
      end else begin : g_line
         logic [33:0] dl_q [LATENCY-1];
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < LATENCY - 1; i++) dl_q[i] <= '0;
            end else begin
               dl_q[0] <= in_w;
               for (int i = 1; i < LATENCY - 1; i++) dl_q[i] <= dl_q[i-1];
            end
         end
         assign push_w = dl_q[LATENCY-2];
      end
   endgenerate
   always_ff @(posedge clk) begin
      if (acc && req_we && !err_w)
         for (int i = 0; i < 4; i++)
            if (req_be[i]) mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
   end
   // No full check: the outstanding credit limit guarantees a free slot on every push
   always_ff @(posedge clk) begin
      if (push) fifo_q[tail_q] <= push_w[32:0];
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q  <= '0;
         fcnt_q <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         out_q  <= out_d;
         fcnt_q <= fcnt_d;
         if (push) tail_q <= nxt(tail_q);
         if (pop) head_q <= nxt(head_q);
      end
   end
endmodule
